// File: rtl/oc8051_ram_param_bist.sv
`default_nettype none
// ============================================================================
// Module  : oc8051_ram_param_bist
// Brief   : Parametrised oc8051 internal RAM with forwarding and an optional
//           March C- self-test (enabled by OC8051_RAM_BIST_EN).
// Rev     : 1.0
// ============================================================================
module oc8051_ram_param_bist #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ADDR_W-1:0]       rd_addr,
   input  logic                    rd_en,
   output logic [DATA_W-1:0]       rd_data,
   input  logic [ADDR_W-1:0]       wr_addr,
   input  logic [DATA_W-1:0]       wr_data,
   input  logic                    wr,
   output logic [DEPTH*DATA_W-1:0] iram,
   input  logic                    bist_start,
   output logic                    bist_busy,
   output logic                    bist_done,
   output logic                    bist_fail,
   output logic [ADDR_W-1:0]       bist_fail_addr
);

   localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

   // Packed storage: element k lands at [k*DATA_W +: DATA_W], which is the
   // flattened layout iram needs.
   logic [DEPTH-1:0][DATA_W-1:0] mem;

   // Effective port controls after BIST/functional arbitration
   logic              p_wr;
   logic              p_rd_en;
   logic [ADDR_W-1:0] p_wr_addr;
   logic [ADDR_W-1:0] p_rd_addr;
   logic [DATA_W-1:0] p_wr_data;

   always_ff @(posedge clk) begin
      if (p_wr && ({1'b0, p_wr_addr} < DEPTH_EXT))
         mem[p_wr_addr[IDX_W-1:0]] <= p_wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data <= '0;
      end else if (p_rd_en) begin
         if (p_wr && (p_wr_addr == p_rd_addr))
            rd_data <= p_wr_data;
         else if ({1'b0, p_rd_addr} >= DEPTH_EXT)
            rd_data <= '0;
         else
            rd_data <= mem[p_rd_addr[IDX_W-1:0]];
      end
   end

   assign iram = mem;

`ifdef OC8051_RAM_BIST_EN
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_W0   = 3'd1,
      S_R0W1 = 3'd2,
      S_R1W0 = 3'd3,
      S_R0   = 3'd4
   } bist_state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH-1);

   bist_state_t       state, state_nxt;
   logic [ADDR_W-1:0] addr, addr_nxt, fail_addr_nxt;
   logic              phase, phase_nxt;
   logic              busy_nxt, done_nxt, fail_nxt;
   logic              b_wr, b_rd_en, cmp;
   logic [DATA_W-1:0] b_wr_data, exp_word;

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         addr           <= '0;
         phase          <= 1'b0;
         bist_busy      <= 1'b0;
         bist_done      <= 1'b0;
         bist_fail      <= 1'b0;
         bist_fail_addr <= '0;
      end else begin
         state          <= state_nxt;
         addr           <= addr_nxt;
         phase          <= phase_nxt;
         bist_busy      <= busy_nxt;
         bist_done      <= done_nxt;
         bist_fail      <= fail_nxt;
         bist_fail_addr <= fail_addr_nxt;
      end
   end

   // phase 0 issues the read, phase 1 compares the registered result and writes
   always_comb begin
      state_nxt     = state;
      addr_nxt      = addr;
      phase_nxt     = phase;
      busy_nxt      = bist_busy;
      done_nxt      = bist_done;
      fail_nxt      = bist_fail;
      fail_addr_nxt = bist_fail_addr;
      b_wr          = 1'b0;
      b_rd_en       = 1'b0;
      b_wr_data     = '0;
      exp_word      = '0;
      cmp           = 1'b0;
      case (state)
         S_IDLE: begin
            if (bist_start) begin
               state_nxt     = S_W0;
               addr_nxt      = '0;
               phase_nxt     = 1'b0;
               busy_nxt      = 1'b1;
               done_nxt      = 1'b0;
               fail_nxt      = 1'b0;
               fail_addr_nxt = '0;
            end
         end
         S_W0: begin
            b_wr = 1'b1;
            if (addr == LAST_ADDR) begin
               state_nxt = S_R0W1;
               addr_nxt  = '0;
            end else begin
               addr_nxt = addr + 1'b1;
            end
         end
         S_R0W1: begin
            if (!phase) begin
               b_rd_en   = 1'b1;
               phase_nxt = 1'b1;
            end else begin
               cmp       = 1'b1;
               b_wr      = 1'b1;
               b_wr_data = '1;
               phase_nxt = 1'b0;
               if (addr == LAST_ADDR) begin
                  state_nxt = S_R1W0;
                  addr_nxt  = LAST_ADDR;
               end else begin
                  addr_nxt = addr + 1'b1;
               end
            end
         end
         S_R1W0: begin
            exp_word = '1;
            if (!phase) begin
               b_rd_en   = 1'b1;
               phase_nxt = 1'b1;
            end else begin
               cmp       = 1'b1;
               b_wr      = 1'b1;
               phase_nxt = 1'b0;
               if (addr == '0) begin
                  state_nxt = S_R0;
               end else begin
                  addr_nxt = addr - 1'b1;
               end
            end
         end
         S_R0: begin
            if (!phase) begin
               b_rd_en   = 1'b1;
               phase_nxt = 1'b1;
            end else begin
               cmp       = 1'b1;
               phase_nxt = 1'b0;
               if (addr == LAST_ADDR) begin
                  state_nxt = S_IDLE;
                  addr_nxt  = '0;
                  busy_nxt  = 1'b0;
                  done_nxt  = 1'b1;
               end else begin
                  addr_nxt = addr + 1'b1;
               end
            end
         end
         default: begin
            state_nxt = S_IDLE;
            busy_nxt  = 1'b0;
         end
      endcase
      if (cmp && (rd_data != exp_word) && !bist_fail) begin
         fail_nxt      = 1'b1;
         fail_addr_nxt = addr;
      end
   end

   assign p_wr      = bist_busy ? b_wr      : wr;
   assign p_wr_addr = bist_busy ? addr      : wr_addr;
   assign p_wr_data = bist_busy ? b_wr_data : wr_data;
   assign p_rd_en   = bist_busy ? b_rd_en   : rd_en;
   assign p_rd_addr = bist_busy ? addr      : rd_addr;
`else
   logic unused_bist_start;
   assign unused_bist_start = bist_start;

   assign bist_busy      = 1'b0;
   assign bist_done      = 1'b0;
   assign bist_fail      = 1'b0;
   assign bist_fail_addr = '0;

   assign p_wr      = wr;
   assign p_wr_addr = wr_addr;
   assign p_wr_data = wr_data;
   assign p_rd_en   = rd_en;
   assign p_rd_addr = rd_addr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_oc8051_ram_param_bist.sv
`default_nettype none
// ============================================================================
// Module  : tb_oc8051_ram_param_bist
// Brief   : Self-checking bench: vector table with scoreboard, plus BIST runs.
// Rev     : 1.0
// ============================================================================
module tb_oc8051_ram_param_bist;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   // instance a: DEPTH=200, functional tests
   logic         rd_en, wr, bist_start;
   logic [7:0]   rd_addr, wr_addr, wr_data, rd_data, bist_fail_addr;
   logic [1599:0] iram;
   logic         bist_busy, bist_done, bist_fail;

   // instance b: DEPTH=16, aliasing and self-test
   logic         b_rd_en, b_wr, b_start;
   logic [7:0]   b_ra, b_wa, b_wd, b_rd, b_fail_addr;
   logic [127:0] b_iram;
   logic         b_busy, b_done, b_fail;

   oc8051_ram_param_bist #(.DATA_W(8), .ADDR_W(8), .DEPTH(200)) dut (
      .clk(clk), .rst(rst),
      .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
      .wr_addr(wr_addr), .wr_data(wr_data), .wr(wr),
      .iram(iram),
      .bist_start(bist_start), .bist_busy(bist_busy), .bist_done(bist_done),
      .bist_fail(bist_fail), .bist_fail_addr(bist_fail_addr)
   );

   oc8051_ram_param_bist #(.DATA_W(8), .ADDR_W(8), .DEPTH(16)) dut_b (
      .clk(clk), .rst(rst),
      .rd_addr(b_ra), .rd_en(b_rd_en), .rd_data(b_rd),
      .wr_addr(b_wa), .wr_data(b_wd), .wr(b_wr),
      .iram(b_iram),
      .bist_start(b_start), .bist_busy(b_busy), .bist_done(b_done),
      .bist_fail(b_fail), .bist_fail_addr(b_fail_addr)
   );

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   typedef struct {
      string      name;
      logic       wr;
      logic [7:0] wa;
      logic [7:0] wd;
      logic       rd_en;
      logic [7:0] ra;
      logic [7:0] exp_rd;
      int         iw;     // iram word to check, -1 for none
      logic [7:0] iexp;
   } vec_t;

   vec_t       vecs[$];
   logic [7:0] sb_q[$];

   function automatic vec_t mk(string n, logic w, logic [7:0] wa, logic [7:0] wd,
                               logic re, logic [7:0] ra, logic [7:0] e,
                               int iw, logic [7:0] ie);
      vec_t v;
      v.name = n; v.wr = w; v.wa = wa; v.wd = wd; v.rd_en = re; v.ra = ra;
      v.exp_rd = e; v.iw = iw; v.iexp = ie;
      return v;
   endfunction

   // Runs instance b until busy drops; returns the edge count, 0 on timeout.
   task automatic run_bist(output int len);
      len = 0;
      for (int k = 1; k <= 300; k++) begin
         @(negedge clk);
         b_start = (k == 30);
         b_wr    = (k == 40);
         b_wa    = 8'h05;
         b_wd    = 8'hAA;
         @(posedge clk); #1;
         if (!b_busy) begin
            len = k;
            break;
         end
      end
      @(negedge clk);
      b_start = 1'b0;
      b_wr    = 1'b0;
   endtask

   int         len;
   logic [7:0] exp_v;

   initial begin
      rst = 1'b0; rd_en = 1'b0; wr = 1'b0; bist_start = 1'b0;
      rd_addr = '0; wr_addr = '0; wr_data = '0;
      b_rd_en = 1'b0; b_wr = 1'b0; b_start = 1'b0; b_ra = '0; b_wa = '0; b_wd = '0;

      vecs.push_back(mk("wr_a5",      1, 8'h10, 8'hA5, 0, 8'h00, 8'h00,  16, 8'hA5));
      vecs.push_back(mk("rd_a5",      0, 8'h00, 8'h00, 1, 8'h10, 8'hA5,  -1, 8'h00));
      vecs.push_back(mk("fwd_last",   1, 8'hC7, 8'hE1, 1, 8'hC7, 8'hE1, 199, 8'hE1));
      vecs.push_back(mk("wr_oor",     1, 8'hC8, 8'h77, 0, 8'h00, 8'hE1, 199, 8'hE1));
      vecs.push_back(mk("rd_oor",     0, 8'h00, 8'h00, 1, 8'hC8, 8'h00,  -1, 8'h00));
      vecs.push_back(mk("fwd_33",     1, 8'h33, 8'h5C, 1, 8'h33, 8'h5C,  51, 8'h5C));
      vecs.push_back(mk("hold1",      1, 8'h34, 8'h11, 0, 8'h33, 8'h5C,  -1, 8'h00));
      vecs.push_back(mk("hold2",      1, 8'h35, 8'h22, 0, 8'h34, 8'h5C,  -1, 8'h00));
      vecs.push_back(mk("hold3",      1, 8'h10, 8'h99, 0, 8'h10, 8'h5C,  16, 8'h99));
      vecs.push_back(mk("rd_34",      0, 8'h00, 8'h00, 1, 8'h34, 8'h11,  -1, 8'h00));
      vecs.push_back(mk("rd_33",      0, 8'h00, 8'h00, 1, 8'h33, 8'h5C,  -1, 8'h00));
      vecs.push_back(mk("rd_c7",      0, 8'h00, 8'h00, 1, 8'hC7, 8'hE1,  -1, 8'h00));
      vecs.push_back(mk("rd_ff",      0, 8'h00, 8'h00, 1, 8'hFF, 8'h00,  -1, 8'h00));
      vecs.push_back(mk("rd_nofwd",   1, 8'h35, 8'h66, 1, 8'h10, 8'h99,  -1, 8'h00));
      vecs.push_back(mk("rd_35",      0, 8'h00, 8'h00, 1, 8'h35, 8'h66,  53, 8'h66));

      // Reset with rd_en high
      @(negedge clk);
      rst = 1'b1; rd_en = 1'b1; b_rd_en = 1'b1;
      @(posedge clk); #1;
      check("rst_rd_data",   rd_data, 8'h00);
      check("rst_b_rd_data", b_rd, 8'h00);
      check("rst_bist_flags", {b_busy, b_done, b_fail, bist_busy, bist_done, bist_fail}, 6'b0);
      check("rst_fail_addr", {b_fail_addr, bist_fail_addr}, 16'h0);
      @(negedge clk);
      rst = 1'b0; rd_en = 1'b0; b_rd_en = 1'b0;

      foreach (vecs[i]) begin
         @(negedge clk);
         wr = vecs[i].wr; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
         rd_en = vecs[i].rd_en; rd_addr = vecs[i].ra;
         sb_q.push_back(vecs[i].exp_rd);
         @(posedge clk); #1;
         exp_v = sb_q.pop_front();
         check(vecs[i].name, rd_data, exp_v);
         if (vecs[i].iw >= 0)
            check({vecs[i].name, "_iram"}, iram[vecs[i].iw*8 +: 8], vecs[i].iexp);
      end
      @(negedge clk);
      wr = 1'b0; rd_en = 1'b0;

      // Out-of-range write must not alias onto a low word when DEPTH < 2^ADDR_W
      b_wr = 1'b1; b_wa = 8'h03; b_wd = 8'h3C;
      @(negedge clk);
      b_wa = 8'h13; b_wd = 8'hFF;
      @(negedge clk);
      b_wr = 1'b0; b_rd_en = 1'b1; b_ra = 8'h03;
      @(posedge clk); #1;
      check("b_alias_rd", b_rd, 8'h3C);
      check("b_alias_iram", b_iram[31:24], 8'h3C);
      @(negedge clk);
      b_ra = 8'h13;
      @(posedge clk); #1;
      check("b_oor_rd", b_rd, 8'h00);
      @(negedge clk);
      b_rd_en = 1'b0;

`ifdef OC8051_RAM_BIST_EN
      // Passing run, with a start retrigger and a functional write mid-test
      b_start = 1'b1;
      @(posedge clk); #1;
      check("bist_busy_rise", b_busy, 1'b1);
      check("bist_done_clr", b_done, 1'b0);
      run_bist(len);
      check("bist_len", len, 112);
      check("bist_pass_done", b_done, 1'b1);
      check("bist_pass_fail", b_fail, 1'b0);
      check("bist_pass_iram", b_iram, 128'h0);

      // Stuck-at-1 on bit 3 of word 9
      force dut_b.mem[9][3] = 1'b1;
      b_start = 1'b1;
      @(posedge clk); #1;
      check("bist2_done_clr", b_done, 1'b0);
      run_bist(len);
      check("bist_fail_len", len, 112);
      check("bist_fail_done", b_done, 1'b1);
      check("bist_fail_flag", b_fail, 1'b1);
      check("bist_fail_addr", b_fail_addr, 8'h09);
      release dut_b.mem[9][3];

      // Abort by reset at cycle 50
      @(negedge clk);
      b_start = 1'b1;
      @(posedge clk); #1;
      check("bist3_fail_clr", b_fail, 1'b0);
      check("bist3_busy", b_busy, 1'b1);
      @(negedge clk);
      b_start = 1'b0;
      for (int k = 2; k < 50; k++) @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check("abort_busy", b_busy, 1'b0);
      check("abort_flags", {b_done, b_fail}, 2'b00);
      @(negedge clk);
      rst = 1'b0;
`else
      b_start = 1'b1;
      @(posedge clk); #1;
      check("nobist_busy", b_busy, 1'b0);
      check("nobist_flags", {b_done, b_fail, b_fail_addr}, 10'h0);
      @(negedge clk);
      b_start = 1'b0;
`endif
      b_wr = 1'b1; b_wa = 8'h07; b_wd = 8'h6B;
      @(negedge clk);
      b_wr = 1'b0; b_rd_en = 1'b1; b_ra = 8'h07;
      @(posedge clk); #1;
      check("post_func_rd", b_rd, 8'h6B);
      @(negedge clk);
      b_rd_en = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/oc8051_ram_param_bist.md
# oc8051_ram_param_bist

Parametrised two-port internal RAM for the oc8051 core, replacing the fixed 16-entry, 8-bit buffer. It provides one synchronous write port and one registered read port with write-to-read forwarding, and exports the full flattened array for the golden-model comparison. An optional March C- style built-in self-test engine drives both ports while active and reports pass/fail plus the first failing address.

## Interface
- `DATA_W`, default 8: word width in bits.
- `ADDR_W`, default 8: address width in bits.
- `DEPTH`, default 256: number of words. Legal range is 2..2^ADDR_W.

Ports:
- `clk`  in  1: sole clock; all state changes on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `rd_addr`  in  ADDR_W: read address.
- `rd_en`  in  1: read enable.
- `rd_data`  out  DATA_W: registered read data.
- `wr_addr`  in  ADDR_W: write address.
- `wr_data`  in  DATA_W: write data.
- `wr`  in  1: write strobe.
- `iram`  out  DEPTH*DATA_W: flattened array; word k sits at bits [k*DATA_W+DATA_W-1 : k*DATA_W].
- `bist_start`  in  1: one-cycle request to start self-test.
- `bist_busy`  out  1: self-test running.
- `bist_done`  out  1: sticky completion flag.
- `bist_fail`  out  1: sticky failure flag.
- `bist_fail_addr`  out  ADDR_W: first failing address.

## Operation
- **Write:** if `wr` and `wr_addr` < `DEPTH`, then `mem[wr_addr]` takes `wr_data` at the edge. Out-of-range writes are dropped.
- **Read:** if `rd_en`, then `rd_data` takes one of the following at the edge:
  - `wr_data`, when `wr` is high and `wr_addr` == `rd_addr` (forwarding, full-width compare).
  - 0, when `rd_addr` >= `DEPTH`.
  - `mem[rd_addr]` otherwise.
- If `rd_en` is low, `rd_data` holds its value.
- **`iram`:** combinational view of `mem`; it reflects a write in the cycle after that write's edge.
- **Reset:** clears `rd_data`, `bist_busy`, `bist_done`, `bist_fail` and `bist_fail_addr` to 0, and returns the BIST FSM to IDLE. Memory contents are not reset.
- **BIST FSM**, states in order IDLE → W0 → R0W1 → R1W0 → R0 → IDLE:
  - **IDLE:** `bist_start` clears `bist_done`, `bist_fail` and `bist_fail_addr`, sets `bist_busy`, moves to W0 with address 0.
  - **W0:** ascending, one cycle per address, writes all-zeros.
  - **R0W1:** ascending, two cycles per address. Cycle A issues the read; cycle B compares `rd_data` against all-zeros, then writes all-ones.
  - **R1W0:** descending from `DEPTH`-1, two cycles per address; expects all-ones, writes all-zeros.
  - **R0:** ascending, two cycles per address (issue, compare); expects all-zeros.
  - **After the last R0 compare:** `bist_busy`=0, `bist_done`=1, back to IDLE.
- **Mismatch:** on the first mismatch, `bist_fail`=1 and `bist_fail_addr` latches the address. Later mismatches leave `bist_fail_addr` unchanged. The test always runs to completion.
- **Port ownership while busy:** the functional `wr`/`rd_en` inputs are ignored. `rd_data` shows the BIST read data. After a passing run every word is 0.
- **Start handling:** `bist_start` while busy is ignored. `bist_start` and a functional `wr` in the same IDLE cycle: the write is performed and BIST starts the next cycle.

## Timing
- Read latency is 1 cycle: address at edge N, data valid after edge N.
- Forwarding is same-cycle: write and read of one address at edge N returns the new data after edge N.
- Write-to-`iram` latency is 1 edge.
- BIST duration is 7*`DEPTH` cycles from the first W0 cycle. `bist_busy` rises at the edge that samples `bist_start`. `bist_done` rises at the edge after the last compare.
- A reset during BIST aborts it: after the reset edge all flags read 0 and the functional ports are live.

## Configuration
- **`OC8051_RAM_BIST_EN` defined:** the BIST FSM, comparator and flags are compiled in, as described above.
- **Undefined:** no BIST logic is built. `bist_busy`, `bist_done`, `bist_fail` and `bist_fail_addr` are tied to 0, `bist_start` is ignored, and the functional ports are always live. Ports are identical in both builds.

## Test plan
- **Reset:** assert `rst` with `rd_en`=1 → `rd_data`=0 and all BIST outputs 0 after the edge.
- **Write/read and range, defaults:**
  - Write 0xA5 to 0x10, next cycle read 0x10 → `rd_data`=0xA5 one cycle later; `iram`[135:128]=0xA5.
  - With `DEPTH`=200, write 0x77 to 0xC8 → no change in `iram`; reading 0xC8 returns 0.
- **Forwarding:** same cycle `wr`=1, `wr_addr`=`rd_addr`=0x33, `wr_data`=0x5C, `rd_en`=1 → `rd_data`=0x5C after that edge.
- **Hold:** load `rd_data`=0x5C, then `rd_en`=0 for 3 cycles with writes to other addresses → `rd_data` stays 0x5C.
- **BIST pass** (`OC8051_RAM_BIST_EN`, `DEPTH`=16): pulse `bist_start` → `bist_busy` high for exactly 112 cycles, then `bist_done`=1, `bist_fail`=0, all `iram` words 0.
- **BIST fail and abort:**
  - Force bit 3 of word 9 stuck at 1 → `bist_fail`=1, `bist_fail_addr`=9 at done.
  - Repeat without the force and assert `rst` at cycle 50 → `bist_busy`=0 and `bist_fail`=0 after the edge; a functional write/read works next cycle.
